// File: rtl/hwpe_stream_package.sv
// Shared types for the HWPE streamer control blocks.
package hwpe_stream_package;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S0   = 2'd1,
    S1   = 2'd2,
    DONE = 2'd3
  } mux_ctrl_state_t;

endpackage

// File: rtl/hwpe_stream_beat_counter.sv
// Loadable, clearable up-counter with a terminal-count flag against a programmable value.
module hwpe_stream_beat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] tc_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule

// File: rtl/hwpe_stream_mux_static_ctrl.sv
// Select sequencer for a two-input static stream mux: alternating bursts of len0/len1 beats
// for a programmed number of rounds, switching only on burst boundaries.
module hwpe_stream_mux_static_ctrl
  import hwpe_stream_package::*;
#(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned RND_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len0_i,
  input  logic [CNT_WIDTH-1:0] len1_i,
  input  logic [RND_WIDTH-1:0] rounds_i,
  input  logic                 out_valid_i,
  input  logic                 out_ready_i,
  output logic                 sel_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] beat_cnt_o,
  output logic [RND_WIDTH-1:0] round_cnt_o
);

  mux_ctrl_state_t state_q;

  logic [CNT_WIDTH-1:0] len0_q, len1_q;
  logic [RND_WIDTH-1:0] rounds_q;
  logic                 sel_q, busy_q, done_q;

  logic                 hs, start_acc, in_burst;
  logic                 burst_end, round_end, last_round;
  logic                 beat_tc, round_tc;
  logic [CNT_WIDTH-1:0] cur_len, beat_tc_val, beat_cnt;
  logic [RND_WIDTH-1:0] round_tc_val, round_cnt;

  assign hs        = out_valid_i & out_ready_i;
  assign start_acc = (state_q == IDLE) & start_i;
  assign in_burst  = (state_q == S0) | (state_q == S1);

  // Burst states are only entered with a non-zero length, so len-1 never underflows there.
  assign cur_len      = (state_q == S1) ? len1_q : len0_q;
  assign beat_tc_val  = cur_len - CNT_WIDTH'(1);
  assign round_tc_val = rounds_q - RND_WIDTH'(1);

  assign burst_end  = in_burst & hs & beat_tc;
  assign round_end  = burst_end & ((state_q == S1) | (len1_q == '0));
  assign last_round = round_end & round_tc;

  hwpe_stream_beat_counter #(
    .WIDTH (CNT_WIDTH)
  ) i_beat_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i | burst_end),
    .load_i     (start_acc),
    .load_val_i ('0),
    .inc_i      (in_burst & hs),
    .tc_val_i   (beat_tc_val),
    .cnt_o      (beat_cnt),
    .tc_o       (beat_tc)
  );

  hwpe_stream_beat_counter #(
    .WIDTH (RND_WIDTH)
  ) i_round_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear_i    (clear_i),
    .load_i     (start_acc),
    .load_val_i ('0),
    .inc_i      (round_end),
    .tc_val_i   (round_tc_val),
    .cnt_o      (round_cnt),
    .tc_o       (round_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q  <= IDLE;
      len0_q   <= '0;
      len1_q   <= '0;
      rounds_q <= '0;
      sel_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            len0_q   <= len0_i;
            len1_q   <= len1_i;
            rounds_q <= rounds_i;
            if ((rounds_i == '0) || ((len0_i == '0) && (len1_i == '0))) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (len0_i == '0) begin
              state_q <= S1;
              sel_q   <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S0;
              sel_q   <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
        end
        S0: begin
          if (burst_end) begin
            if (len1_q != '0) begin
              state_q <= S1;
              sel_q   <= 1'b1;
            end else if (last_round) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
        S1: begin
          if (burst_end) begin
            if (last_round) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (len0_q != '0) begin
              state_q <= S0;
              sel_q   <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sel_o       = sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign beat_cnt_o  = beat_cnt;
  assign round_cnt_o = round_cnt;

endmodule

// File: tb/tb_hwpe_stream_mux_static_ctrl.sv
// Randomised bench: expected per-handshake select/beat/round sequence is built from the burst schedule.
module tb_hwpe_stream_mux_static_ctrl;

  localparam int CW = 16;
  localparam int RW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, start_i;
  logic [CW-1:0] len0_i, len1_i;
  logic [RW-1:0] rounds_i;
  logic          out_valid_i, out_ready_i;
  logic          sel_o, busy_o, done_o;
  logic [CW-1:0] beat_cnt_o;
  logic [RW-1:0] round_cnt_o;

  int total = 0;
  int bad   = 0;
  bit last_sel = 1'b0;

  hwpe_stream_mux_static_ctrl #(
    .CNT_WIDTH (CW),
    .RND_WIDTH (RW)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .len0_i      (len0_i),
    .len1_i      (len1_i),
    .rounds_i    (rounds_i),
    .out_valid_i (out_valid_i),
    .out_ready_i (out_ready_i),
    .sel_o       (sel_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .beat_cnt_o  (beat_cnt_o),
    .round_cnt_o (round_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    out_valid_i = 1'b0; out_ready_i = 1'b0;
    len0_i = '0; len1_i = '0; rounds_i = '0;
    step(); step();
    rst_i = 1'b0;
    total++;
    if ({sel_o, busy_o, done_o} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got sel/busy/done=%b expected 000", {sel_o, busy_o, done_o});
    end
    total++;
    if (beat_cnt_o !== '0 || round_cnt_o !== '0) begin
      bad++; $display("FAIL reset_cnt: got beat=%0d round=%0d expected 0/0", beat_cnt_o, round_cnt_o);
    end
    last_sel = 1'b0;
  endtask

  // One full run. stall: random valid/ready gaps; noise: random start/config while busy;
  // clear_at >= 0: pulse clear_i at the cycle the DUT waits on that handshake index.
  task automatic run(input int l0, input int l1, input int rn, input bit stall, input bit noise,
                     input int clear_at);
    bit es[$];
    int eb[$];
    int er[$];
    int n, idx, cyc;
    for (int r = 0; r < rn; r++) begin
      for (int b = 0; b < l0; b++) begin es.push_back(1'b0); eb.push_back(b); er.push_back(r); end
      for (int b = 0; b < l1; b++) begin es.push_back(1'b1); eb.push_back(b); er.push_back(r); end
    end
    n = es.size();

    len0_i = CW'(l0); len1_i = CW'(l1); rounds_i = RW'(rn);
    start_i = 1'b1;
    out_valid_i = 1'b0; out_ready_i = 1'b0;
    step();
    start_i = 1'b0;

    if (n == 0) begin
      out_valid_i = 1'b1; out_ready_i = 1'b1;
      total++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
        bad++; $display("FAIL degen_done: got done=%b busy=%b expected 1/0 (l0=%0d l1=%0d rn=%0d)", done_o, busy_o, l0, l1, rn);
      end
      total++;
      if (sel_o !== last_sel || round_cnt_o !== '0) begin
        bad++; $display("FAIL degen_hold: got sel=%b round=%0d expected %b/0", sel_o, round_cnt_o, last_sel);
      end
      step();
      out_valid_i = 1'b0; out_ready_i = 1'b0;
      total++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL degen_after: got done=%b busy=%b expected 0/0", done_o, busy_o);
      end
      return;
    end

    idx = 0;
    cyc = 0;
    while (idx < n && cyc < n * 20 + 100) begin
      total++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
        bad++; $display("FAIL run_status: hs#%0d got busy=%b done=%b expected 1/0", idx, busy_o, done_o);
      end
      total++;
      if (sel_o !== es[idx]) begin
        bad++; $display("FAIL run_sel: hs#%0d got %b expected %b (l0=%0d l1=%0d rn=%0d)", idx, sel_o, es[idx], l0, l1, rn);
      end
      total++;
      if (beat_cnt_o !== CW'(eb[idx]) || round_cnt_o !== RW'(er[idx])) begin
        bad++; $display("FAIL run_cnt: hs#%0d got beat=%0d round=%0d expected %0d/%0d", idx, beat_cnt_o, round_cnt_o, eb[idx], er[idx]);
      end
      if (idx == clear_at) begin
        clear_i = 1'b1;
        out_valid_i = 1'b1; out_ready_i = 1'b1;
        step();
        clear_i = 1'b0;
        out_valid_i = 1'b0; out_ready_i = 1'b0;
        total++;
        if ({sel_o, busy_o, done_o} !== 3'b000) begin
          bad++; $display("FAIL clear_flags: got sel/busy/done=%b expected 000", {sel_o, busy_o, done_o});
        end
        total++;
        if (beat_cnt_o !== '0 || round_cnt_o !== '0) begin
          bad++; $display("FAIL clear_cnt: got beat=%0d round=%0d expected 0/0", beat_cnt_o, round_cnt_o);
        end
        last_sel = 1'b0;
        return;
      end
      out_valid_i = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      out_ready_i = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      start_i = noise ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (noise) begin
        len0_i = CW'($urandom_range(0, 7));
        len1_i = CW'($urandom_range(0, 7));
        rounds_i = RW'($urandom_range(0, 7));
      end
      if (out_valid_i && out_ready_i) idx++;
      cyc++;
      step();
    end

    start_i = 1'b0;
    out_valid_i = 1'b0; out_ready_i = 1'b0;
    total++;
    if (idx < n) begin
      bad++; $display("FAIL run_timeout: reached hs#%0d of %0d", idx, n);
    end
    total++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      bad++; $display("FAIL run_done: got done=%b busy=%b expected 1/0", done_o, busy_o);
    end
    total++;
    if (round_cnt_o !== RW'(rn) || beat_cnt_o !== '0 || sel_o !== es[n-1]) begin
      bad++; $display("FAIL run_final: got round=%0d beat=%0d sel=%b expected %0d/0/%b", round_cnt_o, beat_cnt_o, sel_o, rn, es[n-1]);
    end
    last_sel = es[n-1];
    step();
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || sel_o !== last_sel) begin
      bad++; $display("FAIL run_idle: got done=%b busy=%b sel=%b expected 0/0/%b", done_o, busy_o, sel_o, last_sel);
    end
  endtask

  task automatic test_basic();
    run(3, 2, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) run(3, 2, 2, 1'b1, 1'b0, -1);
  endtask

  task automatic test_len0_zero();
    run(0, 4, 3, 1'b0, 1'b0, -1);
    run(0, 4, 3, 1'b1, 1'b0, -1);
  endtask

  task automatic test_degenerate();
    run(5, 3, 0, 1'b0, 1'b0, -1);
    run(0, 0, 4, 1'b0, 1'b0, -1);
  endtask

  task automatic test_clear();
    run(3, 2, 2, 1'b0, 1'b0, 4);
    run(3, 2, 2, 1'b1, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    run(3, 2, 2, 1'b1, 1'b1, -1);
    run(2, 3, 3, 1'b0, 1'b1, -1);
  endtask

  task automatic test_boundary();
    run(1, 0, 255, 1'b0, 1'b0, -1);
    run(0, 1, 255, 1'b1, 1'b0, -1);
    run(1, 1, 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      run($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 4),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_len0_zero();
    test_degenerate();
    test_clear();
    test_start_ignored();
    test_boundary();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
